// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture sequencer: state encoding, opcodes
// and status-byte layout.
package adc_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARG  = 3'd1,
    ST_CAPT = 3'd2,
    ST_FULL = 3'd3,
    ST_READ = 3'd4
  } state_e;

  localparam logic [7:0] OP_ARM    = 8'h01;
  localparam logic [7:0] OP_ABORT  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;

  localparam int STAT_BUSY_BIT = 7;
  localparam int STAT_FULL_BIT = 6;
  localparam int STAT_ERR_BIT  = 5;

  function automatic logic [7:0] status_byte(input logic busy, input logic full,
                                             input logic err, input state_e st);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_FULL_BIT] = full;
    s[STAT_ERR_BIT]  = err;
    s[2:0]           = st;
    return s;
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// SPI byte front-end, ADC bus and status flags of the capture sequencer.
interface adc_capture_ctrl_if;
  logic       frame_start;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic [7:0] adc_d;
  logic       busy;
  logic       full;
  logic       cmd_err;

  modport master (
    output frame_start, cmd_valid, cmd_data, tx_ready, adc_d,
    input  tx_data, busy, full, cmd_err
  );

  modport slave (
    input  frame_start, cmd_valid, cmd_data, tx_ready, adc_d,
    output tx_data, busy, full, cmd_err
  );
endinterface

// File: rtl/adc_capture_ctrl_capture_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read,
// no reset so it maps onto block RAM.
module capture_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Command-driven capture sequencer: decimated ADC block capture into a
// buffer, streamed back over the SPI transmit byte interface on request.
//
// state | meaning
// IDLE  | no block captured or capture aborted
// ARG   | ARM seen, waiting for the decimation byte
// CAPT  | capturing samples, busy
// FULL  | buffer holds a complete block
// READ  | streaming the buffer out through tx_data
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input logic               clk,
  input logic               rst_n,
  adc_capture_ctrl_if.slave io_bus
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        r_state, w_state;
  logic [AW-1:0] r_wr_ptr, w_wr_ptr;
  logic [AW-1:0] r_rd_ptr, w_rd_ptr;
  logic [7:0]    r_decim, w_decim;
  logic [7:0]    r_dcnt, w_dcnt;
  logic          r_full, w_full;
  logic          r_cmd_err, w_cmd_err;
  logic          r_first, w_first;
  logic [7:0]    r_tx_data;
  logic          w_wr_en;
  logic [7:0]    w_ram_q;

  capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(io_bus.adc_d),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(w_ram_q)
  );

  // Capture and read-out advance first so a command in the same clk sees
  // the post-write state; frame_start is applied before the byte decode.
  always_comb begin
    w_state   = r_state;
    w_wr_ptr  = r_wr_ptr;
    w_rd_ptr  = r_rd_ptr;
    w_decim   = r_decim;
    w_dcnt    = r_dcnt;
    w_full    = r_full;
    w_cmd_err = r_cmd_err;
    w_first   = r_first;
    w_wr_en   = 1'b0;

    case (r_state)
      ST_CAPT: begin
        if (r_dcnt == 8'd0) begin
          w_wr_en  = 1'b1;
          w_wr_ptr = r_wr_ptr + 1'b1;
          if (r_wr_ptr == LAST) begin
            w_state = ST_FULL;
            w_full  = 1'b1;
          end
        end
        w_dcnt = (r_dcnt == r_decim) ? 8'd0 : r_dcnt + 8'd1;
      end
      ST_READ: begin
        if (io_bus.tx_ready) begin
          w_rd_ptr = r_rd_ptr + 1'b1;
          if (r_rd_ptr == LAST) w_state = ST_FULL;
        end
      end
      default: ;
    endcase

    if (io_bus.frame_start) begin
      w_first = 1'b1;
      if (w_state == ST_ARG)       w_state = ST_IDLE;
      else if (w_state == ST_READ) w_state = ST_FULL;
    end

    if (io_bus.cmd_valid) begin
      if (w_first) begin
        w_first = 1'b0;
        case (io_bus.cmd_data)
          OP_ARM:    w_state = ST_ARG;
          OP_ABORT: begin
            w_state  = ST_IDLE;
            w_full   = 1'b0;
            w_wr_ptr = '0;
            w_rd_ptr = '0;
            w_dcnt   = 8'd0;
          end
          OP_READ: begin
            if (w_state == ST_FULL) begin
              w_state  = ST_READ;
              w_rd_ptr = '0;
            end else begin
              w_cmd_err = 1'b1;
            end
          end
          OP_STATUS: ;
          default:   w_cmd_err = 1'b1;
        endcase
      end else if (w_state == ST_ARG) begin
        w_decim   = io_bus.cmd_data;
        w_cmd_err = 1'b0;
        w_full    = 1'b0;
        w_wr_ptr  = '0;
        w_dcnt    = 8'd0;
        w_state   = ST_CAPT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_decim   <= 8'd0;
      r_dcnt    <= 8'd0;
      r_full    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_first   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_state   <= w_state;
      r_wr_ptr  <= w_wr_ptr;
      r_rd_ptr  <= w_rd_ptr;
      r_decim   <= w_decim;
      r_dcnt    <= w_dcnt;
      r_full    <= w_full;
      r_cmd_err <= w_cmd_err;
      r_first   <= w_first;
      r_tx_data <= (w_state == ST_READ) ? w_ram_q
                 : status_byte(w_state == ST_CAPT, w_full, w_cmd_err, w_state);
    end
  end

  assign io_bus.tx_data = r_tx_data;
  assign io_bus.busy    = (r_state == ST_CAPT);
  assign io_bus.full    = r_full;
  assign io_bus.cmd_err = r_cmd_err;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized self-checking bench for adc_capture_ctrl against a
// transaction-level model of commands, capture timing and buffer contents.
module tb_adc_capture_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LOGN  = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  adc_capture_ctrl_if bus ();

  adc_capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;
  int last_edge;
  logic [7:0] adc_log [LOGN];

  // Every rising edge is numbered; the ADC value seen at that edge is logged.
  always @(posedge clk) begin
    adc_log[edge_n % LOGN] <= bus.adc_d;
    edge_n <= edge_n + 1;
  end

  initial begin
    bus.adc_d = 8'h00;
    forever begin
      @(negedge clk);
      bus.adc_d = 8'($urandom);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: mode uses the status-byte state codes (0 idle, 1 arg, 2 capt, 3 full, 4 read)
  int         m_mode;
  bit         m_full, m_err;
  logic [7:0] exp_buf [DEPTH];

  function automatic logic [7:0] exp_status();
    return {m_mode == 2, m_full, m_err, 2'b00, 3'(m_mode)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input bit fs, input logic [7:0] b);
    @(negedge clk);
    bus.frame_start = fs;
    bus.cmd_valid   = 1'b1;
    bus.cmd_data    = b;
    last_edge       = edge_n;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    if (m_mode == 1) m_mode = 0;
    if (m_mode == 4) m_mode = 3;
  endtask

  task automatic pulse_txr();
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
  endtask

  // Opcode as first byte of a new frame
  task automatic do_cmd(input logic [7:0] op);
    send_byte(1'b1, op);
    if (m_mode == 1) m_mode = 0;
    if (m_mode == 4) m_mode = 3;
    case (op)
      8'h01: m_mode = 1;
      8'h02: begin m_mode = 0; m_full = 0; end
      8'h03: if (m_mode == 3) m_mode = 4; else m_err = 1;
      8'h04: ;
      default: m_err = 1;
    endcase
    if (m_mode != 4) check($sformatf("status_op%02h", op), bus.tx_data, exp_status());
  endtask

  task automatic arm(input logic [7:0] d, output int ea);
    do_cmd(8'h01);
    send_byte(1'b0, d);
    ea     = last_edge;
    m_mode = 2;
    m_full = 0;
    m_err  = 0;
    check("arm_status", bus.tx_data, exp_status());
  endtask

  task automatic fill_exp(input int ea, input int d);
    for (int i = 0; i < DEPTH; i++)
      exp_buf[i] = adc_log[(ea + 1 + i * (d + 1)) % LOGN];
  endtask

  task automatic wait_full(input int ea, input int d);
    int lim;
    lim = 0;
    while (bus.busy === 1'b1 && lim < 5000) begin
      @(negedge clk);
      lim++;
    end
    check("full_edge", edge_n, ea + 2 + (DEPTH - 1) * (d + 1));
    m_mode = 3;
    m_full = 1;
    check("full_flag", bus.full, 1'b1);
    check("full_status", bus.tx_data, exp_status());
    fill_exp(ea, d);
  endtask

  task automatic read_out();
    for (int i = 0; i < DEPTH; i++) begin
      repeat (2) @(negedge clk);
      check($sformatf("rd_byte%0d", i), bus.tx_data, exp_buf[i]);
      pulse_txr();
    end
    m_mode = 3;
    check("rd_done_status", bus.tx_data, exp_status());
  endtask

  task automatic read_all();
    do_cmd(8'h03);
    read_out();
  endtask

  initial begin
    int ea, busy_seen;
    bus.frame_start = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_data    = 8'h00;
    bus.tx_ready    = 1'b0;
    m_mode = 0; m_full = 0; m_err = 0;

    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx_data, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_full", bus.full, 1'b0);
    check("rst_err", bus.cmd_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tx", bus.tx_data, 8'h00);
    do_cmd(8'h04);

    // Illegal READ and unknown opcode, error cleared by ARM
    do_cmd(8'h03);
    check("err_flag", bus.cmd_err, 1'b1);
    do_cmd(8'h7E);

    arm(8'h00, ea);
    wait_full(ea, 0);
    read_all();

    arm(8'h03, ea);
    wait_full(ea, 3);
    read_all();
    do_cmd(8'h03);
    repeat (2) @(negedge clk);
    check("reread_byte0", bus.tx_data, exp_buf[0]);
    pulse_fs();
    check("fs_in_read", bus.tx_data, exp_status());

    // ABORT while wr_ptr==5, then restart from address 0
    arm(8'h00, ea);
    while (edge_n < ea + 5) @(negedge clk);
    do_cmd(8'h02);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_full", bus.full, 1'b0);
    arm(8'h00, ea);
    wait_full(ea, 0);
    read_all();

    // frame_start between ARM and its argument
    do_cmd(8'h01);
    pulse_fs();
    check("arg_cancel", bus.tx_data, exp_status());
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen++;
    end
    check("arg_cancel_busy", busy_seen, 0);

    // READ arriving in the same clk as the final sample write
    arm(8'h00, ea);
    while (edge_n < ea + 15) @(negedge clk);
    send_byte(1'b1, 8'h03);
    fill_exp(ea, 0);
    m_mode = 4;
    m_full = 1;
    check("coinc_full", bus.full, 1'b1);
    check("coinc_busy", bus.busy, 1'b0);
    read_out();

    for (int it = 0; it < 8; it++) begin
      int d, r;
      bit aborted;
      d = $urandom_range(0, 3);
      arm(8'(d), ea);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      r = $urandom_range(0, 4);
      aborted = 0;
      case (r)
        1: do_cmd(8'h04);
        2: do_cmd(8'($urandom_range(5, 255)));
        3: do_cmd(8'h03);
        4: begin
          do_cmd(8'h02);
          aborted = 1;
          check("rnd_abort_busy", bus.busy, 1'b0);
        end
        default: ;
      endcase
      if (!aborted) begin
        wait_full(ea, d);
        check("rnd_err", bus.cmd_err, m_err);
        read_all();
      end
    end

    // Asynchronous reset in the middle of a read-out
    arm(8'h02, ea);
    wait_full(ea, 2);
    do_cmd(8'h03);
    repeat (2) @(negedge clk);
    check("pre_rst_byte0", bus.tx_data, exp_buf[0]);
    pulse_txr();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", bus.tx_data, 8'h00);
    check("async_rst_busy", bus.busy, 1'b0);
    check("async_rst_full", bus.full, 1'b0);
    check("async_rst_err", bus.cmd_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_mode = 0; m_full = 0; m_err = 0;
    do_cmd(8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
